// File: rtl/alu_logic_sequencer.sv
// Command sequencer for the 8-bit logic unit: buffers requests in a small FIFO,
// issues each one as a single-cycle enable pulse and holds its result for downstream.
module alu_logic_sequencer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [1:0]  cmd_op,
   output logic [7:0]  lu_a,
   output logic [7:0]  lu_b,
   output logic [1:0]  lu_s2,
   output logic        lu_en2,
   input  logic [15:0] lu_out2,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   output logic [1:0]  res_op,
   output logic [15:0] ops_done
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;
   typedef struct packed {
      logic [1:0] op;
      logic [7:0] b;
      logic [7:0] a;
   } cmd_t;

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   cmd_t             mem_q [DEPTH];
   cmd_t             head;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push, pop, fifo_empty;

   state_t           state_q;
   logic [1:0]       op_q;
   logic [7:0]       lu_a_q, lu_b_q;
   logic [1:0]       lu_s2_q;
   logic             lu_en2_q;
   logic             res_valid_q;
   logic [15:0]      res_data_q;
   logic [1:0]       res_op_q;
   logic [15:0]      ops_done_q;

   assign head       = mem_q[rd_ptr_q];
   assign fifo_empty = (count_q == '0);
   assign cmd_ready  = (count_q != FULL_CNT);
   assign push       = cmd_valid && cmd_ready;
   // The head leaves the FIFO on the edge that ends the ISSUE cycle.
   assign pop        = (state_q == ISSUE);

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)
         count_d = count_q + CNT_ONE;
      else if (pop && !push)
         count_d = count_q - CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= {cmd_op, cmd_b, cmd_a};
   end

   // Logic-unit drive is loaded on entry to ISSUE so it is valid for exactly that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= '0;
         lu_a_q      <= '0;
         lu_b_q      <= '0;
         lu_s2_q     <= '0;
         lu_en2_q    <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_op_q    <= '0;
         ops_done_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  state_q  <= ISSUE;
                  lu_a_q   <= head.a;
                  lu_b_q   <= head.b;
                  lu_s2_q  <= head.op;
                  lu_en2_q <= 1'b1;
               end
            end
            ISSUE: begin
               op_q     <= head.op;
               lu_a_q   <= '0;
               lu_b_q   <= '0;
               lu_s2_q  <= '0;
               lu_en2_q <= 1'b0;
               state_q  <= CAPTURE;
            end
            CAPTURE: begin
               // The unit clears its output on this edge; we take the pre-edge result.
               res_data_q  <= lu_out2;
               res_op_q    <= op_q;
               res_valid_q <= 1'b1;
               state_q     <= HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  ops_done_q  <= ops_done_q + 16'd1;
                  if (!fifo_empty) begin
                     state_q  <= ISSUE;
                     lu_a_q   <= head.a;
                     lu_b_q   <= head.b;
                     lu_s2_q  <= head.op;
                     lu_en2_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign lu_a      = lu_a_q;
   assign lu_b      = lu_b_q;
   assign lu_s2     = lu_s2_q;
   assign lu_en2    = lu_en2_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_op    = res_op_q;
   assign ops_done  = ops_done_q;

endmodule
